// File: rtl/sme_match_collector.sv
// Packs SME rule-ID matches into 32-bit rule/EOP records behind a FWFT record FIFO with a per-packet cap.
// Optional macro SME_MATCH_DEDUP_EN drops a rule ID equal to the previous written ID of the same packet.
module sme_match_collector #(
    parameter int FIFO_DEPTH  = 16,
    parameter int MAX_MATCHES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] match_rule_ID,
    input  logic        match_valid,
    input  logic        match_last,
    output logic        match_release,
    output logic [31:0] rec_data,
    output logic        rec_valid,
    input  logic        rec_ready,
    output logic [31:0] pkt_count,
    output logic [31:0] match_count,
    output logic [31:0] drop_count,
    output logic        eop_lost
);

    localparam int         AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH   = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] OCC_LIM = (AW+1)'(FIFO_DEPTH - 2);
    localparam logic [7:0]  CAP     = 8'(MAX_MATCHES);

    // Handshakes: a rule ID moves when match_valid & match_release in the same cycle,
    // a record moves when rec_valid & rec_ready; match_last is a bare pulse with no qualifier.

    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   occ;

    logic [7:0]  cnt;
    logic        ovf;
    logic        eop_pend;

    logic        full;
    logic        room2;
    logic        at_cap;
    logic        take;
    logic        cap_drop;
    logic        dup;
    logic        rule_wr;
    logic        last_new;
    logic        pend_wr;
    logic        direct_wr;
    logic        eop_wr;
    logic        push;
    logic        pop;
    logic        eop_ovf;
    logic [31:0] push_data;

    assign full   = (occ == DEPTH);
    assign room2  = (occ <= OCC_LIM);
    assign at_cap = (cnt == CAP);

    // One slot stays reserved for the EOP record; a capped packet keeps draining without FIFO use.
    assign match_release = ~rst & ((room2 & ~eop_pend) | at_cap);

    assign take     = match_valid & match_release;
    assign cap_drop = take & at_cap;
    assign rule_wr  = take & ~at_cap & ~dup;

`ifdef SME_MATCH_DEDUP_EN
    logic [15:0] last_id;
    logic        last_vld;

    assign dup = take & ~at_cap & last_vld & (match_rule_ID == last_id);

    always_ff @(posedge clk) begin
        if (rst) begin
            last_id  <= 16'd0;
            last_vld <= 1'b0;
        end else if (eop_wr) begin
            last_vld <= 1'b0;
        end else if (rule_wr) begin
            last_id  <= match_rule_ID;
            last_vld <= 1'b1;
        end
    end
`else
    assign dup = 1'b0;
`endif

    // A pulse that coincides with an accepted rule is deferred so the rule lands first and is counted.
    assign last_new  = match_last & ~eop_pend;
    assign pend_wr   = eop_pend & ~full;
    assign direct_wr = last_new & ~take & ~full;
    assign eop_wr    = pend_wr | direct_wr;

    // A cap drop in the same cycle as a deferred EOP still belongs to the ending packet.
    assign eop_ovf   = ovf | cap_drop;
    assign push      = rule_wr | eop_wr;
    assign push_data = eop_wr ? {1'b1, 14'd0, eop_ovf, 8'd0, cnt} : {16'd0, match_rule_ID};

    assign rec_valid = (occ != '0);
    assign rec_data  = rec_valid ? mem[rd_ptr] : 32'd0;
    assign pop       = rec_valid & rec_ready;

    always_ff @(posedge clk) begin
        if (push & ~rst) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            occ         <= '0;
            cnt         <= 8'd0;
            ovf         <= 1'b0;
            eop_pend    <= 1'b0;
            eop_lost    <= 1'b0;
            pkt_count   <= 32'd0;
            match_count <= 32'd0;
            drop_count  <= 32'd0;
        end else begin
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            if (eop_wr) begin
                cnt <= 8'd0;
                ovf <= 1'b0;
            end else if (rule_wr) begin
                cnt <= cnt + 8'd1;
            end else if (cap_drop) begin
                ovf <= 1'b1;
            end

            if (pend_wr) begin
                eop_pend <= 1'b0;
            end else if (last_new & (take | full)) begin
                eop_pend <= 1'b1;
            end
            if (match_last & eop_pend) begin
                eop_lost <= 1'b1;
            end

            if (eop_wr) begin
                pkt_count <= pkt_count + 32'd1;
            end
            if (rule_wr) begin
                match_count <= match_count + 32'd1;
            end
            if (cap_drop | dup) begin
                drop_count <= drop_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_sme_match_collector.sv
// Randomized and directed bench for sme_match_collector with a queue-based record scoreboard.
// Honours SME_MATCH_DEDUP_EN the same way the design does.
module tb_sme_match_collector;

    localparam int D    = 4;
    localparam int MAXM = 4;
`ifdef SME_MATCH_DEDUP_EN
    localparam bit DEDUP = 1'b1;
`else
    localparam bit DEDUP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] match_rule_ID = 16'd0;
    logic        match_valid = 1'b0;
    logic        match_last = 1'b0;
    logic        match_release;
    logic [31:0] rec_data;
    logic        rec_valid;
    logic        rec_ready = 1'b0;
    logic [31:0] pkt_count;
    logic [31:0] match_count;
    logic [31:0] drop_count;
    logic        eop_lost;

    sme_match_collector #(.FIFO_DEPTH(D), .MAX_MATCHES(MAXM)) dut (
        .clk(clk), .rst(rst),
        .match_rule_ID(match_rule_ID), .match_valid(match_valid), .match_last(match_last),
        .match_release(match_release),
        .rec_data(rec_data), .rec_valid(rec_valid), .rec_ready(rec_ready),
        .pkt_count(pkt_count), .match_count(match_count), .drop_count(drop_count),
        .eop_lost(eop_lost)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    // Reference model: records in flight, current packet tally, statistics.
    int          m_occ, m_cnt, m_pkt, m_match, m_drop;
    bit          m_ovf, m_pend, m_lost, m_lv;
    logic [15:0] m_lid;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_occ = 0; m_cnt = 0; m_pkt = 0; m_match = 0; m_drop = 0;
        m_ovf = 0; m_pend = 0; m_lost = 0; m_lv = 0; m_lid = 16'd0;
        exp_q.delete();
    endtask

    task automatic push_eop();
        exp_q.push_back({1'b1, 14'd0, m_ovf, 8'd0, 8'(m_cnt)});
        m_cnt = 0; m_ovf = 0; m_lv = 0; m_pkt++;
    endtask

    // One clock of stimulus; checks visible outputs against the model, then advances the model.
    task automatic drive_cycle(input bit mv, input logic [15:0] id, input bit last, input bit rdy,
                               output bit took, output bit rel_seen);
        bit rel, wrote, eop, pend0;
        int occ0;
        @(negedge clk);
        rst = 1'b0;
        match_valid = mv; match_rule_ID = id; match_last = last; rec_ready = rdy;
        #1;
        rel = ((D - m_occ) >= 2 && !m_pend) || (m_cnt == MAXM);
        rel_seen = match_release;
        check("match_release", {31'd0, match_release}, {31'd0, rel});
        check("rec_valid", {31'd0, rec_valid}, {31'd0, m_occ != 0});
        check("pkt_count", pkt_count, 32'(m_pkt));
        check("match_count", match_count, 32'(m_match));
        check("drop_count", drop_count, 32'(m_drop));
        check("eop_lost", {31'd0, eop_lost}, {31'd0, m_lost});

        took = mv && rel; wrote = 0; eop = 0;
        occ0 = m_occ; pend0 = m_pend;
        if (took) begin
            if (m_cnt == MAXM) begin
                m_ovf = 1; m_drop++;
            end else if (DEDUP && m_lv && id == m_lid) begin
                m_drop++;
            end else begin
                exp_q.push_back({16'd0, id});
                m_cnt++; m_match++; m_lv = 1; m_lid = id; wrote = 1;
            end
        end
        if (pend0 && occ0 < D) begin
            push_eop(); m_pend = 0; eop = 1;
        end
        if (last) begin
            if (pend0) m_lost = 1;
            else if (took) m_pend = 1;
            else if (occ0 < D) begin push_eop(); eop = 1; end
            else m_pend = 1;
        end
        m_occ = occ0 + int'(wrote) + int'(eop) - int'(occ0 > 0 && rdy);
    endtask

    task automatic idle(input int n, input bit rdy);
        bit t, r;
        for (int i = 0; i < n; i++) drive_cycle(0, 16'd0, 0, rdy, t, r);
    endtask

    task automatic send_rule(input logic [15:0] id, input bit last, input bit rdy);
        bit t, r;
        int tries;
        t = 0; tries = 0;
        while (!t && tries < 64) begin
            drive_cycle(1, id, last, rdy, t, r);
            tries++;
        end
        check("send_accepted", {31'd0, t}, 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; match_valid = 0; match_last = 0; rec_ready = 0; match_rule_ID = 16'd0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_release", {31'd0, match_release}, 32'd0);
        check("rst_rec_valid", {31'd0, rec_valid}, 32'd0);
        check("rst_rec_data", rec_data, 32'd0);
        check("rst_pkt", pkt_count, 32'd0);
        check("rst_match", match_count, 32'd0);
        check("rst_drop", drop_count, 32'd0);
        check("rst_lost", {31'd0, eop_lost}, 32'd0);
        model_reset();
    endtask

    // Monitor: every record the core pops must be the oldest expected one.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (rst === 1'b0 && rec_valid === 1'b1 && rec_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_rec: got 0x%08h expected none at %0t", rec_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("rec_data", rec_data, e);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bit t, r;
        model_reset();

        // Two rules then end of packet.
        do_reset();
        send_rule(16'h0011, 0, 1);
        send_rule(16'h0022, 0, 1);
        drive_cycle(0, 16'd0, 1, 1, t, r);
        idle(6, 1);
        check("t1_pkt", pkt_count, 32'd1);
        check("t1_match", match_count, 32'd2);
        check("t1_drained", 32'(exp_q.size()), 32'd0);

        // Cap: six IDs, four kept, release stays high.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive_cycle(1, 16'(16'h0040 + i), 0, 1, t, r);
            check("t2_release_high", {31'd0, r}, 32'd1);
        end
        drive_cycle(0, 16'd0, 1, 1, t, r);
        idle(6, 1);
        check("t2_match", match_count, 32'd4);
        check("t2_drop", drop_count, 32'd2);
        check("t2_pkt", pkt_count, 32'd1);

        // Backpressure: three rules fit, EOP takes the reserved slot.
        do_reset();
        for (int i = 0; i < 6; i++) drive_cycle(1, 16'(16'h0100 + i), 0, 0, t, r);
        drive_cycle(0, 16'd0, 1, 0, t, r);
        check("t3_release_low", {31'd0, r}, 32'd0);
        idle(2, 0);
        check("t3_match", match_count, 32'd3);
        check("t3_pkt", pkt_count, 32'd1);
        idle(6, 1);
        send_rule(16'h01AA, 0, 1);
        idle(3, 1);
        check("t3_resume", match_count, 32'd4);

        // Full FIFO, pending EOP, then a lost pulse.
        do_reset();
        for (int i = 0; i < 3; i++) drive_cycle(1, 16'(16'h0200 + i), 0, 0, t, r);
        for (int i = 0; i < 3; i++) drive_cycle(0, 16'd0, 1, 0, t, r);
        idle(2, 0);
        check("t4_lost", {31'd0, eop_lost}, 32'd1);
        check("t4_pkt_full", pkt_count, 32'd1);
        idle(8, 1);
        check("t4_pkt_drained", pkt_count, 32'd2);
        check("t4_drained", 32'(exp_q.size()), 32'd0);

        // Rule and end of packet in the same cycle.
        do_reset();
        drive_cycle(1, 16'h0033, 1, 1, t, r);
        idle(5, 1);
        check("t5_pkt", pkt_count, 32'd1);
        check("t5_match", match_count, 32'd1);

        // Repeated IDs.
        do_reset();
        send_rule(16'd5, 0, 1);
        send_rule(16'd5, 0, 1);
        send_rule(16'd7, 0, 1);
        send_rule(16'd5, 0, 1);
        drive_cycle(0, 16'd0, 1, 1, t, r);
        idle(6, 1);
        check("t6_match", match_count, DEDUP ? 32'd3 : 32'd4);
        check("t6_drop", drop_count, DEDUP ? 32'd1 : 32'd0);

        // Reset mid-packet leaves nothing behind.
        do_reset();
        send_rule(16'h0300, 0, 0);
        send_rule(16'h0301, 0, 0);
        do_reset();
        idle(4, 1);
        check("t7_pkt", pkt_count, 32'd0);

        // Randomized traffic.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            bit mv, lst, rdy;
            mv  = ($urandom_range(0, 9) < 6);
            lst = ($urandom_range(0, 9) == 0);
            rdy = ((i / 64) % 3 == 2) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 1) == 1);
            drive_cycle(mv, 16'($urandom_range(0, 7)), lst, rdy, t, r);
        end
        idle(20, 1);
        check("final_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
